uart_rx_fifo: RTL

Parametrised UART receiver with a built-in show-ahead receive FIFO. It is the successor to the single-byte receive path.
- Deserialises 8N1-style frames with configurable data width and stop length.
- Oversamples using the shared baud-rate s_tick.
- Buffers received words so the MIPS debug/loader unit can drain them at its own pace.
- Reports framing and overrun errors.

---
 rtl/uart_rx_fifo.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (start / NB_DATA data / stop, oversampled on s_tick) feeding a show-ahead receive FIFO.
// Optional parity stage and parity_err port are compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          s_tick,
  input  logic                          rd_en,
  output logic [NB_DATA-1:0]            dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          rx_done_tick,
  output logic                          frame_err,
  output logic                          overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [2:0]                    o_dbg_state
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] NB_LAST    = BW'(NB_DATA - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
  localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
  localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

  // Receiver registers
  logic               r_rx_meta;
  logic               r_rx_sync;
  state_t             r_state;
  logic [TW-1:0]      r_tick_cnt;
  logic [BW-1:0]      r_bit_cnt;
  logic [NB_DATA-1:0] r_shift;
  logic               r_done;
  logic               r_ferr;

  // FIFO registers
  logic [NB_DATA-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_oerr;

  logic w_par_ok;
  logic w_stop_sample;
  logic w_push;
  logic w_pop;
  logic w_wr;
  logic w_full;
  logic w_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_perr;
  assign w_par_ok   = ((^r_shift) ^ r_par_bit) == (PARITY_ODD != 0);
  assign parity_err = r_perr;
`else
  assign w_par_ok = 1'b1;
`endif

  // Final stop-bit tick: the one cycle in which a frame is judged.
  assign w_stop_sample = (r_state == ST_STOP) && s_tick && (r_tick_cnt == STOP_LAST);
  assign w_push        = w_stop_sample && r_rx_sync && w_par_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (!r_rx_sync) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (r_tick_cnt == START_LAST) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              // A start bit that is already high again at mid-bit was a glitch.
              r_state    <= r_rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (r_tick_cnt == BIT_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {r_rx_sync, r_shift[NB_DATA-1:1]};
              if (r_bit_cnt == NB_LAST) begin
                r_state <= ST_AFTER_DATA;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (r_tick_cnt == BIT_LAST) begin
              r_tick_cnt <= '0;
              r_par_bit  <= r_rx_sync;
              r_state    <= ST_STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (s_tick) begin
            if (r_tick_cnt == STOP_LAST) begin
              r_tick_cnt <= '0;
              r_state    <= ST_IDLE;
              // Framing error outranks parity error; only one pulse per frame.
              if (!r_rx_sync) begin
                r_ferr <= 1'b1;
              end else if (w_par_ok) begin
                r_done <= 1'b1;
              end else begin
`ifdef UART_RX_PARITY_EN
                r_perr <= 1'b1;
`endif
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read side: !empty acts as valid and rd_en as ready; a pop happens only when both are high.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_pop   = rd_en && !w_empty;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_oerr   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_oerr <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout         = r_mem[r_rd_ptr];
  assign empty        = w_empty;
  assign full         = w_full;
  assign count        = r_count;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign overrun_err  = r_oerr;
  assign o_dbg_state  = r_state;

endmodule
